box_fill_engine: RTL and testbench
==================================

Name: box_fill_engine

Overview:
Parametrised rectangle fill engine. Writes a caller-supplied colour to every pixel of an axis-aligned box in a row-major frame-buffer memory, one pixel per accepted write. It is the general successor to the fixed black-only star cleaner and adds these features:
- programmable fill colour
- corner normalisation
- bounds checking
- write back-pressure
- abort
- pixel count reporting

It sits between the star-detection control FSM and the frame-buffer write port.

Parameters:
X_SZ, 3, width of x coordinates
Y_SZ, 3, width of y coordinates
COL_SZ, 3, colour width
IMG_W, 6, image width in pixels (row pitch)
IMG_H, 6, image height in pixels
ADDR_SZ, 6, memory address width (must hold IMG_W*IMG_H-1)
CNT_SZ, 7, pixel counter width (must hold (2^X_SZ)*(2^Y_SZ))

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
go  in  1  start request, sampled only in IDLE
x0  in  X_SZ  box corner A x
x1  in  X_SZ  box corner B x
y0  in  Y_SZ  box corner A y
y1  in  Y_SZ  box corner B y
fill_col  in  COL_SZ  colour to write
mem_ready  in  1  memory accepts the write presented this cycle
abort  in  1  terminate the current fill
addr_out  out  ADDR_SZ  write address
col_out  out  COL_SZ  write data
wr_en  out  1  write request
busy  out  1  high in WRITE
done  out  1  one-cycle completion pulse
err  out  1  last request was out of bounds
aborted  out  1  last request ended by abort
pix_count  out  CNT_SZ  writes accepted for the last/current request

Behaviour:
- One clock is used: clk. Reset is asynchronous and active-low on resetn.
- Reset values:
  - state = IDLE
  - all counters and latches = 0
  - wr_en, busy, done, err, aborted = 0
  - pix_count = 0
  - addr_out = 0, col_out = 0
- States: IDLE, WRITE, DONE.
- IDLE, go=1 at a clock edge: latch the box and colour, and clear pix_count, err and aborted.
  - Normalise corners: xl=min(x0,x1), xr=max(x0,x1), yt=min(y0,y1), yb=max(y0,y1).
  - Load xc=xl and yc=yt; latch fill_col.
  - If xr>=IMG_W or yb>=IMG_H: set err=1 and go to DONE. No writes are issued.
  - Otherwise go to WRITE.
- WRITE:
  - wr_en=1 and busy=1.
  - addr_out = yc*IMG_W + xc, computed in ADDR_SZ-bit unsigned arithmetic with zero-extended operands. It is combinational from the counter registers.
  - col_out = latched colour.
- In WRITE, a write is accepted when wr_en & mem_ready at a clock edge. Each accepted write increments pix_count. Address advance on an accepted write:
  - xc!=xr: xc+1.
  - xc==xr and yc!=yb: xc=xl, yc+1.
  - xc==xr and yc==yb: go to DONE.
- mem_ready=0: counters, addr_out and col_out hold, and wr_en stays high.
- abort=1 in WRITE has priority over a simultaneous accept. The write presented that cycle is not counted. Set aborted=1 and go to DONE.
- abort is ignored in IDLE and DONE.
- DONE: done=1 for exactly one cycle, wr_en=0, busy=0, then IDLE.
- go is ignored in WRITE and DONE; it is not queued.
- err, aborted and pix_count hold until the next accepted go.
- Latency with a W x H box and mem_ready always 1:
  - first wr_en in the cycle after the go edge
  - W*H consecutive wr_en cycles
  - done in the following cycle
- Degenerate box: x0==x1 and y0==y1 gives exactly one write.
- Input latching: coordinate or colour changes after go is accepted have no effect.
- Reset mid-fill: immediate return to IDLE with all outputs at their reset values. No done pulse is generated.
- Counters never wrap: xc<=xr<IMG_W is guaranteed by the bounds check.

Test Plan:
- Basic fill, defaults: box (1,1)-(2,2), fill_col=3'b101, mem_ready=1.
  -> wr_en for 4 cycles with addr 7, 8, 13, 14 and col_out 5 throughout.
  -> done pulse one cycle later; pix_count=4, err=0.
- Swapped corners: x0=4, x1=2, y0=3, y1=3.
  -> addresses 20, 21, 22; pix_count=3.
- Back-pressure: box (0,0)-(1,0), mem_ready low for 2 cycles on the first pixel.
  -> addr 0 held 3 cycles, then addr 1.
  -> done after the 2 accepted writes; pix_count=2.
- Bounds error: x1=6 (IMG_W=6).
  -> no wr_en; done one cycle after go; err=1, pix_count=0.
- Abort: box (0,0)-(5,5); abort asserted on the 3rd wr_en cycle together with mem_ready=1.
  -> pix_count=2, aborted=1; done the next cycle; no further writes.
- Reset and ignored go:
  - Assert resetn=0 mid-fill. -> all outputs at reset values asynchronously, with no done pulse.
  - Pulse go during WRITE of a new fill. -> the running fill completes unchanged and exactly one done pulse is produced.

Source files
------------

// File: rtl/box_fill_engine_if.sv
// Request/status and frame-buffer write-port signals of the box fill engine.
// The master side is the star-detection controller plus the memory; the engine uses the slave side.
interface box_fill_engine_if #(
  parameter int X_SZ    = 3,
  parameter int Y_SZ    = 3,
  parameter int COL_SZ  = 3,
  parameter int ADDR_SZ = 6,
  parameter int CNT_SZ  = 7
);
  logic                go;
  logic [X_SZ-1:0]     x0;
  logic [X_SZ-1:0]     x1;
  logic [Y_SZ-1:0]     y0;
  logic [Y_SZ-1:0]     y1;
  logic [COL_SZ-1:0]   fill_col;
  logic                mem_ready;
  logic                abort;
  logic [ADDR_SZ-1:0]  addr_out;
  logic [COL_SZ-1:0]   col_out;
  logic                wr_en;
  logic                busy;
  logic                done;
  logic                err;
  logic                aborted;
  logic [CNT_SZ-1:0]   pix_count;

  modport master (
    output go, x0, x1, y0, y1, fill_col, mem_ready, abort,
    input  addr_out, col_out, wr_en, busy, done, err, aborted, pix_count
  );

  modport slave (
    input  go, x0, x1, y0, y1, fill_col, mem_ready, abort,
    output addr_out, col_out, wr_en, busy, done, err, aborted, pix_count
  );
endinterface

// File: rtl/box_fill_engine.sv
// Rectangle fill engine: writes a latched colour to every pixel of a normalised,
// bounds-checked box in a row-major frame buffer, one pixel per accepted write.
//
// state | meaning
// IDLE  | waiting for go; box, colour and status latched on go
// WRITE | presenting one pixel write per cycle until last accept or abort
// DONE  | one-cycle done pulse, then back to IDLE
module box_fill_engine #(
  parameter int X_SZ    = 3,
  parameter int Y_SZ    = 3,
  parameter int COL_SZ  = 3,
  parameter int IMG_W   = 6,
  parameter int IMG_H   = 6,
  parameter int ADDR_SZ = 6,
  parameter int CNT_SZ  = 7
) (
  input  logic              clk,
  input  logic              resetn,
  box_fill_engine_if.slave  bus
);
  localparam logic [31:0] IMG_W_U = IMG_W;
  localparam logic [31:0] IMG_H_U = IMG_H;

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [X_SZ-1:0]     xl, xr, xc;
  logic [Y_SZ-1:0]     yt, yb, yc;
  logic [COL_SZ-1:0]   col;
  logic [CNT_SZ-1:0]   pix_count;
  logic                err;
  logic                aborted;

  logic [X_SZ-1:0]     xl_n, xr_n;
  logic [Y_SZ-1:0]     yt_n, yb_n;
  logic                oob;
  logic                accept;
  logic                last;

  always_comb begin
    xl_n   = (bus.x0 <= bus.x1) ? bus.x0 : bus.x1;
    xr_n   = (bus.x0 <= bus.x1) ? bus.x1 : bus.x0;
    yt_n   = (bus.y0 <= bus.y1) ? bus.y0 : bus.y1;
    yb_n   = (bus.y0 <= bus.y1) ? bus.y1 : bus.y0;
    oob    = (32'(xr_n) >= IMG_W_U) || (32'(yb_n) >= IMG_H_U);
    // abort wins over a simultaneous accept, so the presented write is dropped
    accept = (state == WRITE) && bus.mem_ready && !bus.abort;
    last   = (xc == xr) && (yc == yb);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.go) state_nxt = oob ? DONE : WRITE;
      WRITE: if (bus.abort || (accept && last)) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      xl        <= '0;
      xr        <= '0;
      xc        <= '0;
      yt        <= '0;
      yb        <= '0;
      yc        <= '0;
      col       <= '0;
      pix_count <= '0;
      err       <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      if (state == IDLE && bus.go) begin
        xl        <= xl_n;
        xr        <= xr_n;
        yt        <= yt_n;
        yb        <= yb_n;
        xc        <= xl_n;
        yc        <= yt_n;
        col       <= bus.fill_col;
        pix_count <= '0;
        err       <= oob;
        aborted   <= 1'b0;
      end else if (state == WRITE) begin
        if (bus.abort) begin
          aborted <= 1'b1;
        end else if (accept) begin
          pix_count <= pix_count + 1'b1;
          if (xc != xr) begin
            xc <= xc + 1'b1;
          end else if (yc != yb) begin
            xc <= xl;
            yc <= yc + 1'b1;
          end
        end
      end
    end
  end

  assign bus.wr_en     = (state == WRITE);
  assign bus.busy      = (state == WRITE);
  assign bus.done      = (state == DONE);
  assign bus.addr_out  = ADDR_SZ'(yc) * ADDR_SZ'(IMG_W) + ADDR_SZ'(xc);
  assign bus.col_out   = col;
  assign bus.err       = err;
  assign bus.aborted   = aborted;
  assign bus.pix_count = pix_count;
endmodule

// File: tb/tb_box_fill_engine.sv
// Directed bench for box_fill_engine: hand-computed address sequences, status and timing.
module tb_box_fill_engine;
  logic clk;
  logic resetn;
  int   n_cmp;
  int   n_mis;

  box_fill_engine_if #(.X_SZ(3), .Y_SZ(3), .COL_SZ(3), .ADDR_SZ(6), .CNT_SZ(7)) bfi ();

  box_fill_engine #(
    .X_SZ(3), .Y_SZ(3), .COL_SZ(3), .IMG_W(6), .IMG_H(6), .ADDR_SZ(6), .CNT_SZ(7)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bfi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int addr_q[$];
  int col_q[$];
  int first_wr;
  int done_at;
  int done_cnt;

  task automatic start(input int ax0, input int ax1, input int ay0, input int ay1, input int c);
    @(negedge clk);
    bfi.x0 = 3'(ax0);
    bfi.x1 = 3'(ax1);
    bfi.y0 = 3'(ay0);
    bfi.y1 = 3'(ay1);
    bfi.fill_col = 3'(c);
    bfi.go = 1'b1;
    @(negedge clk);
    bfi.go = 1'b0;
  endtask

  // cycle 0 is the cycle right after the go edge
  task automatic collect(input int budget, input int ready_from, input int abort_at, input int go_at);
    addr_q.delete();
    col_q.delete();
    first_wr = -1;
    done_at  = -1;
    done_cnt = 0;
    for (int i = 0; i < budget; i++) begin
      bfi.mem_ready = (i >= ready_from);
      bfi.abort     = (i == abort_at);
      bfi.go        = (i == go_at);
      #1;
      if (bfi.wr_en === 1'b1) begin
        addr_q.push_back(int'(bfi.addr_out));
        col_q.push_back(int'(bfi.col_out));
        if (first_wr < 0) first_wr = i;
      end
      if (bfi.done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
      end
      @(negedge clk);
    end
    bfi.mem_ready = 1'b1;
    bfi.abort     = 1'b0;
    bfi.go        = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    #1;
    n_cmp++; if (bfi.wr_en !== 1'b0) begin n_mis++; $display("FAIL reset_wr_en got %b want 0", bfi.wr_en); end
    n_cmp++; if (bfi.busy !== 1'b0) begin n_mis++; $display("FAIL reset_busy got %b want 0", bfi.busy); end
    n_cmp++; if (bfi.done !== 1'b0) begin n_mis++; $display("FAIL reset_done got %b want 0", bfi.done); end
    n_cmp++; if (bfi.err !== 1'b0 || bfi.aborted !== 1'b0) begin n_mis++; $display("FAIL reset_status got err=%b aborted=%b want 0 0", bfi.err, bfi.aborted); end
    n_cmp++; if (bfi.pix_count !== 7'd0) begin n_mis++; $display("FAIL reset_pix_count got %0d want 0", bfi.pix_count); end
    n_cmp++; if (bfi.addr_out !== 6'd0 || bfi.col_out !== 3'd0) begin n_mis++; $display("FAIL reset_bus got addr=%0d col=%0d want 0 0", bfi.addr_out, bfi.col_out); end
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int exp_a[4] = '{7, 8, 13, 14};
    start(1, 2, 1, 2, 5);
    collect(8, 0, -1, -1);
    n_cmp++; if (addr_q.size() != 4) begin n_mis++; $display("FAIL basic_nwrites got %0d want 4", addr_q.size()); end
    for (int i = 0; i < 4 && i < addr_q.size(); i++) begin
      n_cmp++; if (addr_q[i] != exp_a[i]) begin n_mis++; $display("FAIL basic_addr[%0d] got %0d want %0d", i, addr_q[i], exp_a[i]); end
      n_cmp++; if (col_q[i] != 5) begin n_mis++; $display("FAIL basic_col[%0d] got %0d want 5", i, col_q[i]); end
    end
    n_cmp++; if (first_wr != 0) begin n_mis++; $display("FAIL basic_first_wr got %0d want 0", first_wr); end
    n_cmp++; if (done_at != 4 || done_cnt != 1) begin n_mis++; $display("FAIL basic_done got at=%0d cnt=%0d want at=4 cnt=1", done_at, done_cnt); end
    n_cmp++; if (bfi.pix_count !== 7'd4 || bfi.err !== 1'b0) begin n_mis++; $display("FAIL basic_status got pix=%0d err=%b want 4 0", bfi.pix_count, bfi.err); end
  endtask

  task automatic test_swapped;
    int exp_a[3] = '{20, 21, 22};
    start(4, 2, 3, 3, 2);
    collect(8, 0, -1, -1);
    n_cmp++; if (addr_q.size() != 3) begin n_mis++; $display("FAIL swap_nwrites got %0d want 3", addr_q.size()); end
    for (int i = 0; i < 3 && i < addr_q.size(); i++) begin
      n_cmp++; if (addr_q[i] != exp_a[i]) begin n_mis++; $display("FAIL swap_addr[%0d] got %0d want %0d", i, addr_q[i], exp_a[i]); end
    end
    n_cmp++; if (done_at != 3) begin n_mis++; $display("FAIL swap_done_at got %0d want 3", done_at); end
    n_cmp++; if (bfi.pix_count !== 7'd3) begin n_mis++; $display("FAIL swap_pix_count got %0d want 3", bfi.pix_count); end
  endtask

  task automatic test_backpressure;
    int exp_a[4] = '{0, 0, 0, 1};
    start(0, 1, 0, 0, 6);
    collect(8, 2, -1, -1);
    n_cmp++; if (addr_q.size() != 4) begin n_mis++; $display("FAIL bp_wr_cycles got %0d want 4", addr_q.size()); end
    for (int i = 0; i < 4 && i < addr_q.size(); i++) begin
      n_cmp++; if (addr_q[i] != exp_a[i] || col_q[i] != 6) begin n_mis++; $display("FAIL bp_cycle[%0d] got addr=%0d col=%0d want addr=%0d col=6", i, addr_q[i], col_q[i], exp_a[i]); end
    end
    n_cmp++; if (done_at != 4) begin n_mis++; $display("FAIL bp_done_at got %0d want 4", done_at); end
    n_cmp++; if (bfi.pix_count !== 7'd2) begin n_mis++; $display("FAIL bp_pix_count got %0d want 2", bfi.pix_count); end
  endtask

  task automatic test_bounds;
    start(0, 6, 0, 1, 1);
    collect(4, 0, -1, -1);
    n_cmp++; if (addr_q.size() != 0) begin n_mis++; $display("FAIL oob_nwrites got %0d want 0", addr_q.size()); end
    n_cmp++; if (done_at != 0 || done_cnt != 1) begin n_mis++; $display("FAIL oob_done got at=%0d cnt=%0d want at=0 cnt=1", done_at, done_cnt); end
    n_cmp++; if (bfi.err !== 1'b1 || bfi.pix_count !== 7'd0) begin n_mis++; $display("FAIL oob_status got err=%b pix=%0d want 1 0", bfi.err, bfi.pix_count); end
  endtask

  task automatic test_abort;
    start(0, 5, 0, 5, 4);
    collect(8, 0, 2, -1);
    n_cmp++; if (bfi.err !== 1'b0) begin n_mis++; $display("FAIL abort_err_cleared got %b want 0", bfi.err); end
    n_cmp++; if (addr_q.size() != 3) begin n_mis++; $display("FAIL abort_wr_cycles got %0d want 3", addr_q.size()); end
    n_cmp++; if (done_at != 3 || done_cnt != 1) begin n_mis++; $display("FAIL abort_done got at=%0d cnt=%0d want at=3 cnt=1", done_at, done_cnt); end
    n_cmp++; if (bfi.pix_count !== 7'd2 || bfi.aborted !== 1'b1) begin n_mis++; $display("FAIL abort_status got pix=%0d aborted=%b want 2 1", bfi.pix_count, bfi.aborted); end
  endtask

  task automatic test_reset_mid_fill;
    int saw_done;
    start(0, 5, 0, 5, 7);
    @(negedge clk);
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    n_cmp++; if (bfi.wr_en !== 1'b0 || bfi.busy !== 1'b0 || bfi.done !== 1'b0) begin n_mis++; $display("FAIL rst_mid_ctrl got wr_en=%b busy=%b done=%b want 0 0 0", bfi.wr_en, bfi.busy, bfi.done); end
    n_cmp++; if (bfi.addr_out !== 6'd0 || bfi.col_out !== 3'd0 || bfi.pix_count !== 7'd0) begin n_mis++; $display("FAIL rst_mid_data got addr=%0d col=%0d pix=%0d want 0 0 0", bfi.addr_out, bfi.col_out, bfi.pix_count); end
    saw_done = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 2) resetn = 1'b1;
      #1;
      if (bfi.done === 1'b1 || bfi.wr_en === 1'b1) saw_done++;
    end
    n_cmp++; if (saw_done != 0) begin n_mis++; $display("FAIL rst_mid_quiet got %0d active cycles want 0", saw_done); end
  endtask

  task automatic test_ignored_go;
    int exp_a[3] = '{0, 1, 2};
    start(0, 2, 0, 0, 3);
    bfi.x0 = 3'd5;
    bfi.x1 = 3'd5;
    bfi.y0 = 3'd5;
    bfi.y1 = 3'd5;
    bfi.fill_col = 3'd1;
    collect(10, 0, -1, 1);
    n_cmp++; if (addr_q.size() != 3) begin n_mis++; $display("FAIL igo_nwrites got %0d want 3", addr_q.size()); end
    for (int i = 0; i < 3 && i < addr_q.size(); i++) begin
      n_cmp++; if (addr_q[i] != exp_a[i] || col_q[i] != 3) begin n_mis++; $display("FAIL igo_cycle[%0d] got addr=%0d col=%0d want addr=%0d col=3", i, addr_q[i], col_q[i], exp_a[i]); end
    end
    n_cmp++; if (done_cnt != 1 || done_at != 3) begin n_mis++; $display("FAIL igo_done got cnt=%0d at=%0d want cnt=1 at=3", done_cnt, done_at); end
    n_cmp++; if (bfi.pix_count !== 7'd3) begin n_mis++; $display("FAIL igo_pix_count got %0d want 3", bfi.pix_count); end
  endtask

  task automatic test_degenerate;
    start(4, 4, 2, 2, 2);
    collect(6, 0, -1, -1);
    n_cmp++; if (addr_q.size() != 1) begin n_mis++; $display("FAIL degen_nwrites got %0d want 1", addr_q.size()); end
    n_cmp++; if (addr_q.size() > 0 && addr_q[0] != 16) begin n_mis++; $display("FAIL degen_addr got %0d want 16", addr_q[0]); end
    n_cmp++; if (done_at != 1 || bfi.pix_count !== 7'd1) begin n_mis++; $display("FAIL degen_done got at=%0d pix=%0d want at=1 pix=1", done_at, bfi.pix_count); end
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    bfi.go = 1'b0;
    bfi.x0 = '0;
    bfi.x1 = '0;
    bfi.y0 = '0;
    bfi.y1 = '0;
    bfi.fill_col = '0;
    bfi.mem_ready = 1'b1;
    bfi.abort = 1'b0;
    test_reset();
    test_basic();
    test_swapped();
    test_backpressure();
    test_bounds();
    test_abort();
    test_degenerate();
    test_reset_mid_fill();
    test_ignored_go();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
